// File: rtl/rodizio_motores_n_if.sv
`default_nettype none
// ============================================================================
// Module   : rodizio_motores_n_if
// Purpose  : Button, level, mask and motor-drive signals of the round-robin
//            motor rotation controller.
// Revision : 1.0 - initial release
// ============================================================================
interface rodizio_motores_n_if #(
  parameter int N_MOTORS = 4,
  parameter int IDXW     = $clog2(N_MOTORS)
);
  logic                btn_start;
  logic                btn_stop;
  logic                btn_reset;
  logic                test_mode;
  logic [N_MOTORS-1:0] motor_en;
  logic [N_MOTORS-1:0] motor_on;
  logic [IDXW-1:0]     active_idx;
  logic                running;
  logic                timer_led;
  logic                heartbeat;
  logic                fault;

  // Board side: drives buttons and mask, observes the drives and LEDs
  modport master (
    output btn_start, btn_stop, btn_reset, test_mode, motor_en,
    input  motor_on, active_idx, running, timer_led, heartbeat, fault
  );

  // Controller side
  modport slave (
    input  btn_start, btn_stop, btn_reset, test_mode, motor_en,
    output motor_on, active_idx, running, timer_led, heartbeat, fault
  );
endinterface
`default_nettype wire

// File: rtl/rodizio_motores_n.sv
`default_nettype none
// ============================================================================
// Module   : rodizio_motores_n
// Purpose  : Round-robin rotation controller for N_MOTORS motors. One motor
//            runs at a time for a programmable number of seconds, with an
//            optional all-off gap; masked motors are skipped.
// Revision : 1.0 - initial release
// ============================================================================
module rodizio_motores_n #(
  parameter int N_MOTORS   = 4,
  parameter int CLK_HZ     = 25_000_000,
  parameter int T_NORMAL_S = 30,
  parameter int T_TEST_S   = 3,
  parameter int DEAD_S     = 0,
  parameter int DB_MS      = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  rodizio_motores_n_if.slave bus
);
  localparam int          IDXW       = $clog2(N_MOTORS);
  localparam int          c_db_raw   = CLK_HZ / 1000 * DB_MS;
  localparam int          c_db_cyc   = (c_db_raw < 1) ? 1 : c_db_raw;
  localparam int          c_dbw      = $clog2(c_db_cyc + 1);
  localparam int          c_prew     = $clog2(CLK_HZ);
  localparam logic [15:0] c_t_normal = 16'(T_NORMAL_S);
  localparam logic [15:0] c_t_test   = 16'(T_TEST_S);
  localparam logic [15:0] c_dead     = 16'(DEAD_S);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DEAD = 2'd2} state_t;

  // Channel order: 0 start, 1 stop, 2 reset, 3 test level
  logic [3:0]          w_raw;
  logic [3:0]          r_sync1, r_sync2;
  logic [3:0]          w_stable;
  logic [2:0]          r_pulse_d;
  logic [N_MOTORS-1:0] r_en1, r_en2;
  logic                w_start_p, w_stop_p, w_reset_p, w_test;

  assign w_raw = {bus.test_mode, bus.btn_reset, bus.btn_stop, bus.btn_start};

  // Two-flop synchronisers for buttons, test level and the enable mask
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_en1   <= '0;
      r_en2   <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
      r_en1   <= bus.motor_en;
      r_en2   <= r_en1;
    end
  end

  generate
    for (genvar g = 0; g < 4; g++) begin : g_db
      logic [c_dbw-1:0] r_cnt;
      logic             r_stb;
      // Accept a new level once it has disagreed for c_db_cyc+1 cycles in a row
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_cnt <= '0;
          r_stb <= 1'b0;
        end else if (r_sync2[g] != r_stb) begin
          if (r_cnt == c_dbw'(c_db_cyc)) begin
            r_stb <= r_sync2[g];
            r_cnt <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end else begin
          r_cnt <= '0;
        end
      end
      assign w_stable[g] = r_stb;
    end
  endgenerate

  // Delayed debounced buttons for single-cycle rising-edge pulses
  always_ff @(posedge clk) begin
    if (!rst_n) r_pulse_d <= '0;
    else        r_pulse_d <= w_stable[2:0];
  end

  assign w_start_p = w_stable[0] & ~r_pulse_d[0];
  assign w_stop_p  = w_stable[1] & ~r_pulse_d[1];
  assign w_reset_p = w_stable[2] & ~r_pulse_d[2];
  assign w_test    = w_stable[3];

  logic [c_prew-1:0] r_pre_cnt, r_tl_cnt, r_hb_cnt;
  logic              r_tl, r_hb, w_tick;

  assign w_tick = (r_pre_cnt == c_prew'(CLK_HZ - 1));

  // Free-running prescalers: 1 Hz tick, 1 Hz timer LED phase, ~2 Hz heartbeat
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pre_cnt <= '0;
      r_tl_cnt  <= '0;
      r_hb_cnt  <= '0;
      r_tl      <= 1'b0;
      r_hb      <= 1'b0;
    end else begin
      r_pre_cnt <= w_tick ? '0 : r_pre_cnt + 1'b1;
      if (r_tl_cnt == c_prew'(CLK_HZ / 2 - 1)) begin
        r_tl_cnt <= '0;
        r_tl     <= ~r_tl;
      end else begin
        r_tl_cnt <= r_tl_cnt + 1'b1;
      end
      if (r_hb_cnt == c_prew'(CLK_HZ / 4 - 1)) begin
        r_hb_cnt <= '0;
        r_hb     <= ~r_hb;
      end else begin
        r_hb_cnt <= r_hb_cnt + 1'b1;
      end
    end
  end

  // First enabled index at base+off, base+off+1, ... (wrapping); the whole
  // ring is scanned, so with off=1 the base itself is the last candidate.
  function automatic logic [IDXW-1:0] f_search(input logic [IDXW-1:0] base,
                                               input logic [N_MOTORS-1:0] mask,
                                               input int off);
    logic [IDXW-1:0] res;
    int              j;
    res = base;
    for (int k = N_MOTORS - 1; k >= 0; k--) begin
      j = int'(base) + off + k;
      if (j >= N_MOTORS) j = j - N_MOTORS;
      if (mask[IDXW'(j)]) res = IDXW'(j);
    end
    return res;
  endfunction

  state_t          r_state, w_state_nxt;
  logic [IDXW-1:0] r_idx, w_idx_nxt, w_first, w_next;
  logic [15:0]     r_sec, w_target;
  logic            r_fault, w_fault_nxt, w_clr, w_any;

  assign w_any    = |r_en2;
  assign w_first  = f_search(r_idx, r_en2, 0);
  assign w_next   = f_search(r_idx, r_en2, 1);
  assign w_target = w_test ? c_t_test : c_t_normal;

  // Next-state decision in priority order: reset, stop, start, mask drop / expiry
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_fault_nxt = r_fault;
    w_clr       = 1'b0;
    if (w_reset_p) begin
      w_state_nxt = S_IDLE;
      w_idx_nxt   = '0;
      w_fault_nxt = 1'b0;
      w_clr       = 1'b1;
    end else if (w_stop_p) begin
      if (r_state != S_IDLE) begin
        w_state_nxt = S_IDLE;
        w_clr       = 1'b1;
      end
    end else if (w_start_p && r_state == S_IDLE) begin
      w_clr = 1'b1;
      if (w_any) begin
        w_state_nxt = S_RUN;
        w_idx_nxt   = w_first;
        w_fault_nxt = 1'b0;
      end else begin
        w_fault_nxt = 1'b1;
      end
    end else begin
      case (r_state)
        S_RUN: begin
          if (!r_en2[r_idx] || r_sec >= w_target) begin
            w_clr = 1'b1;
            if (!w_any) begin
              w_state_nxt = S_IDLE;
              w_fault_nxt = 1'b1;
            end else if (DEAD_S > 0) begin
              w_state_nxt = S_DEAD;
            end else begin
              w_idx_nxt = w_next;
            end
          end
        end
        S_DEAD: begin
          if (r_sec >= c_dead) begin
            w_clr = 1'b1;
            if (!w_any) begin
              w_state_nxt = S_IDLE;
              w_fault_nxt = 1'b1;
            end else begin
              w_state_nxt = S_RUN;
              w_idx_nxt   = w_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // State, rotation pointer, fault flag and saturating seconds counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_fault <= 1'b0;
      r_sec   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_fault <= w_fault_nxt;
      if (w_clr)
        r_sec <= '0;
      else if (w_tick && r_state != S_IDLE && r_sec != 16'hFFFF)
        r_sec <= r_sec + 16'd1;
    end
  end

  assign bus.motor_on   = (r_state == S_RUN) ? (N_MOTORS'(1) << r_idx) : '0;
  assign bus.active_idx = r_idx;
  assign bus.running    = (r_state != S_IDLE);
  assign bus.timer_led  = (r_state != S_IDLE) & r_tl;
  assign bus.heartbeat  = r_hb;
  assign bus.fault      = r_fault;
endmodule
`default_nettype wire

// File: tb/tb_rodizio_motores_n.sv
`default_nettype none
// ============================================================================
// Module   : tb_rodizio_motores_n
// Purpose  : Self-checking bench for the rotation controller: directed
//            scenarios followed by random button/mask/test activity, all
//            compared each cycle against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rodizio_motores_n;
  localparam int N   = 4;
  localparam int CLK = 1000;
  localparam int TN  = 4;
  localparam int TT  = 2;
  localparam int DS  = 1;
  localparam int DBC = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  rodizio_motores_n_if #(.N_MOTORS(N)) bus ();

  rodizio_motores_n #(
    .N_MOTORS(N), .CLK_HZ(CLK), .T_NORMAL_S(TN), .T_TEST_S(TT), .DEAD_S(DS), .DB_MS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [3:0] m_raw_p1, m_raw_p2, m_stab, m_prev, m_en_p1, m_en_p2;
  bit [3:0] m_hist[$];
  int       m_n, m_state, m_idx, m_sec;
  bit       m_fault, m_valid;

  function automatic int next_en(input int from, input bit [3:0] m);
    for (int k = 0; k < N; k++)
      if (m[(from + k) % N]) return (from + k) % N;
    return from;
  endfunction

  function automatic logic [9:0] model_out();
    bit [3:0] mo;
    bit       run;
    run = (m_state != 0);
    mo  = (m_state == 1) ? 4'(1 << m_idx) : 4'b0;
    return {mo, 2'(m_idx), run, run && ((m_n / (CLK / 2)) % 2 == 1),
            ((m_n / (CLK / 4)) % 2 == 1), m_fault};
  endfunction

  always @(posedge clk) begin
    bit [3:0] raw, syn, en;
    bit       sp, tp, rp, tick, trans, all_diff;
    int       tgt, os;
    m_valid = 1'b1;
    raw = {bus.test_mode, bus.btn_reset, bus.btn_stop, bus.btn_start};
    if (!rst_n) begin
      m_raw_p1 = 0; m_raw_p2 = 0; m_stab = 0; m_prev = 0; m_en_p1 = 0; m_en_p2 = 0;
      m_hist.delete();
      m_n = 0; m_state = 0; m_idx = 0; m_sec = 0; m_fault = 0;
    end else begin
      syn = m_raw_p2; m_raw_p2 = m_raw_p1; m_raw_p1 = raw;
      en  = m_en_p2;  m_en_p2  = m_en_p1;  m_en_p1  = bus.motor_en;
      sp = m_stab[0] & ~m_prev[0];
      tp = m_stab[1] & ~m_prev[1];
      rp = m_stab[2] & ~m_prev[2];
      tgt  = m_stab[3] ? TT : TN;
      tick = ((m_n + 1) % CLK) == 0;
      os = m_state;
      trans = 1'b0;
      if (rp) begin
        m_state = 0; m_idx = 0; m_fault = 0; trans = 1;
      end else if (tp) begin
        if (m_state != 0) begin m_state = 0; trans = 1; end
      end else if (sp && m_state == 0) begin
        trans = 1;
        if (en != 0) begin m_state = 1; m_idx = next_en(m_idx, en); m_fault = 0; end
        else m_fault = 1;
      end else if (m_state == 1 && (!en[m_idx] || m_sec >= tgt)) begin
        trans = 1;
        if (en == 0) begin m_state = 0; m_fault = 1; end
        else m_state = 2;
      end else if (m_state == 2 && m_sec >= DS) begin
        trans = 1;
        if (en == 0) begin m_state = 0; m_fault = 1; end
        else begin m_state = 1; m_idx = next_en((m_idx + 1) % N, en); end
      end
      if (trans) m_sec = 0;
      else if (tick && os != 0 && m_sec < 65535) m_sec++;
      // debounce: a level is accepted once DBC+1 consecutive synced samples disagree
      m_prev = m_stab;
      m_hist.push_back(syn);
      if (m_hist.size() > DBC + 1) void'(m_hist.pop_front());
      if (m_hist.size() == DBC + 1)
        for (int ch = 0; ch < 4; ch++) begin
          all_diff = 1'b1;
          foreach (m_hist[k]) if (m_hist[k][ch] == m_stab[ch]) all_diff = 1'b0;
          if (all_diff) m_stab[ch] = syn[ch];
        end
      m_n++;
    end
  end

  // Cycle-by-cycle comparison of every output against the model
  always @(negedge clk) begin
    if (m_valid)
      chk("outputs{on,idx,run,tled,hb,fault}",
          {bus.motor_on, bus.active_idx, bus.running, bus.timer_led, bus.heartbeat, bus.fault},
          model_out());
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // b = {reset, stop, start}
  task automatic btn(input bit [2:0] b, input int hold);
    bus.btn_start = b[0]; bus.btn_stop = b[1]; bus.btn_reset = b[2];
    cyc(hold);
    bus.btn_start = 0; bus.btn_stop = 0; bus.btn_reset = 0;
    cyc(4);
  endtask

  task automatic wait_on(input logic [3:0] exp, input int budget);
    int k = 0;
    while (bus.motor_on !== exp && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (k >= budget) chk("wait_motor_on_timeout", bus.motor_on, exp);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.btn_start = 0; bus.btn_stop = 0; bus.btn_reset = 0;
    bus.test_mode = 0; bus.motor_en = 4'b1111;
    // 1 reset / idle
    cyc(3);
    chk("reset_motor_on", bus.motor_on, 0);
    chk("reset_running", bus.running, 0);
    chk("reset_fault", bus.fault, 0);
    chk("reset_heartbeat", bus.heartbeat, 0);
    rst_n = 1;
    cyc(249);
    chk("hb_before_250", bus.heartbeat, 0);
    cyc(1);
    chk("hb_at_250", bus.heartbeat, 1);
    // 2 rotation, 4 stop/resume vs reset
    btn(3'b001, 4);
    chk("rot_first", bus.motor_on, 4'b0001);
    wait_on(4'b0010, 7000);
    chk("rot_idx1", bus.active_idx, 1);
    wait_on(4'b0100, 7000);
    btn(3'b010, 4);
    chk("stop_running", bus.running, 0);
    chk("stop_idx", bus.active_idx, 2);
    btn(3'b001, 4);
    chk("resume_on", bus.motor_on, 4'b0100);
    cyc(2900);
    chk("resume_full_timer", bus.motor_on, 4'b0100);
    btn(3'b100, 4);
    chk("reset_idx", bus.active_idx, 0);
    btn(3'b001, 4);
    chk("reset_start_on", bus.motor_on, 4'b0001);
    // 3 skip + test mode
    btn(3'b100, 4);
    bus.test_mode = 1; bus.motor_en = 4'b0101;
    cyc(10);
    btn(3'b001, 4);
    chk("skip_first", bus.motor_on, 4'b0001);
    wait_on(4'b0100, 4000);
    wait_on(4'b0001, 4000);
    wait_on(4'b0100, 4000);
    cyc(500);
    bus.motor_en = 4'b0001;
    cyc(4);
    chk("mask_drop_gap_on", bus.motor_on, 0);
    chk("mask_drop_gap_run", bus.running, 1);
    wait_on(4'b0001, 2000);
    // 5 fault
    btn(3'b100, 4);
    bus.test_mode = 0; bus.motor_en = 4'b0000;
    cyc(6);
    btn(3'b001, 4);
    chk("fault_running", bus.running, 0);
    chk("fault_set", bus.fault, 1);
    bus.motor_en = 4'b0010;
    cyc(4);
    btn(3'b001, 4);
    chk("fault_recover_on", bus.motor_on, 4'b0010);
    chk("fault_cleared", bus.fault, 0);
    // 6 debounce / priority
    btn(3'b010, 4);
    for (int i = 0; i < 5; i++) begin
      bus.btn_start = i[0] ? 1'b0 : 1'b1;
      cyc(1);
    end
    btn(3'b001, 6);
    chk("chatter_running", bus.running, 1);
    btn(3'b010, 4);
    btn(3'b011, 4);
    chk("stop_start_idle", bus.running, 0);
    btn(3'b001, 4);
    btn(3'b110, 4);
    chk("reset_stop_idx", bus.active_idx, 0);
    chk("reset_stop_run", bus.running, 0);
    // random activity
    for (int it = 0; it < 250; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: btn(3'b001, $urandom_range(1, 5));
        3:       btn(3'b010, $urandom_range(1, 5));
        4:       btn(3'b100, $urandom_range(1, 5));
        5:       btn(3'($urandom_range(0, 7)), $urandom_range(1, 5));
        6, 7:    bus.motor_en = 4'($urandom_range(0, 15));
        default: bus.test_mode = ~bus.test_mode;
      endcase
      cyc($urandom_range(1, 200));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
